// File: rtl/ram_2p_clr.sv
// Single-clock simple-dual-port RAM with a hardware clear sweep and a registered read port.
// Optional stored even parity with error injection is enabled by defining RAM_PARITY_EN.
module ram_2p_clr #(
  parameter int ADDR_LENGTH = 2,
  parameter int DATA_LENGTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [ADDR_LENGTH-1:0] wr_addr,
  input  logic [DATA_LENGTH-1:0] wr_data,
`ifdef RAM_PARITY_EN
  input  logic                   par_inj,
  output logic                   par_err,
`endif
  input  logic                   rd_en,
  input  logic [ADDR_LENGTH-1:0] rd_addr,
  output logic [DATA_LENGTH-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   busy
);

  localparam int DEPTH = 1 << ADDR_LENGTH;
`ifdef RAM_PARITY_EN
  localparam int MW = DATA_LENGTH + 1;
`else
  localparam int MW = DATA_LENGTH;
`endif

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_LENGTH-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_LENGTH-1:0] rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;

  logic [MW-1:0]          mem [DEPTH];
  logic                   mem_we;
  logic [ADDR_LENGTH-1:0] mem_waddr;
  logic [MW-1:0]          mem_wdata;
  logic [MW-1:0]          wr_word, rd_word;
  logic                   user_ok;

`ifdef RAM_PARITY_EN
  logic par_err_q, par_err_d;
  assign wr_word = {(^wr_data) ^ par_inj, wr_data};
`else
  assign wr_word = wr_data;
`endif

  // clr in IDLE pre-empts any user access issued in the same cycle
  assign user_ok = (state_q == IDLE) && !clr;
  // write-first: a same-address write is forwarded to the read register
  assign rd_word = (wr_en && (wr_addr == rd_addr)) ? wr_word : mem[rd_addr];

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = wr_word;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
`ifdef RAM_PARITY_EN
    par_err_d  = par_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == ADDR_LENGTH'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
    if (user_ok && wr_en) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr;
      mem_wdata = wr_word;
    end
    if (user_ok && rd_en) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rd_word[DATA_LENGTH-1:0];
`ifdef RAM_PARITY_EN
      // XOR over data and stored bit is 1 exactly when they disagree
      par_err_d  = ^rd_word;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef RAM_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
`ifdef RAM_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  // storage has no reset; the clear sweep zeroes it after release
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == CLEAR);
`ifdef RAM_PARITY_EN
  assign par_err  = par_err_q;
`endif

endmodule

// File: tb/tb_ram_2p_clr.sv
// Scoreboard bench for ram_2p_clr: reads push expected words, a negedge monitor pops and compares.
module tb_ram_2p_clr;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       par_inj = 1'b0;
  logic       rd_en = 1'b0;
  logic [1:0] rd_addr = '0;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       par_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] d;
    logic       p;
  } exp_t;
  exp_t exp_q[$];

  ram_2p_clr #(.ADDR_LENGTH(2), .DATA_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef RAM_PARITY_EN
    .par_inj(par_inj), .par_err(par_err),
`endif
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
  );

`ifndef RAM_PARITY_EN
  assign par_err = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] d, input logic inj);
    wr_en = 1'b1; wr_addr = a; wr_data = d; par_inj = inj;
    step();
    wr_en = 1'b0; par_inj = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [3:0] d, input logic p);
    exp_t e;
    e.d = d; e.p = p;
    rd_en = 1'b1; rd_addr = a;
    exp_q.push_back(e);
    step();
    rd_en = 1'b0;
  endtask

  // counts busy cycles sampled at negedge; rd_valid must stay low while busy
  task automatic count_busy(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      chk({name, "_rd_valid_busy"}, {31'b0, rd_valid}, 32'd0);
    end
    chk({name, "_busy_cycles"}, n, 32'd4);
  endtask

  always @(negedge clk) begin
    if (!reset && rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid: got rd_data %0h with no read pending at %0t", rd_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rd_data", {28'b0, rd_data}, {28'b0, e.d});
`ifdef RAM_PARITY_EN
        chk("par_err", {31'b0, par_err}, {31'b0, e.p});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // 1: reset state, sweep length, array reads zero
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd1);
    chk("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("reset_rd_data", {28'b0, rd_data}, 32'd0);
    chk("reset_par_err", {31'b0, par_err}, 32'd0);
    step();
    reset = 1'b0;
    count_busy("t1");
    for (int a = 0; a < 4; a++) rd(2'(a), 4'h0, 1'b0);

    // 2: plain writes and reads, then hold
    wr(2'd1, 4'hA, 1'b0);
    wr(2'd2, 4'h5, 1'b0);
    rd(2'd1, 4'hA, 1'b0);
    rd(2'd2, 4'h5, 1'b0);
    step();
    @(negedge clk);
    chk("t2_idle_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("t2_idle_rd_data", {28'b0, rd_data}, 32'h5);

    // 3: same-cycle write/read is write-first
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 4'hC;
    rd(2'd3, 4'hC, 1'b0);
    wr_en = 1'b0;
    rd(2'd3, 4'hC, 1'b0);

    // 4: fill, clr with concurrent write and read, reads ignored while busy
    for (int a = 0; a < 4; a++) wr(2'(a), 4'hF, 1'b0);
    clr = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'h7; rd_en = 1'b1; rd_addr = 2'd0;
    step();
    clr = 1'b0; wr_en = 1'b0; rd_addr = 2'd1;
    count_busy("t4");
    rd_en = 1'b0;
    chk("t4_rd_data_hold", {28'b0, rd_data}, 32'hC);
    for (int a = 0; a < 4; a++) rd(2'(a), 4'h0, 1'b0);

    // 5: reset mid-sweep restarts a full sweep
    for (int a = 0; a < 4; a++) wr(2'(a), 4'h9, 1'b0);
    rd(2'd3, 4'h9, 1'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("t5_reset_busy", {31'b0, busy}, 32'd1);
    chk("t5_reset_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("t5_reset_rd_data", {28'b0, rd_data}, 32'd0);
    step();
    reset = 1'b0;
    count_busy("t5");
    for (int a = 0; a < 4; a++) rd(2'(a), 4'h0, 1'b0);

`ifdef RAM_PARITY_EN
    // 6: injected parity error is reported on read and on bypass
    wr(2'd0, 4'h3, 1'b0);
    wr(2'd1, 4'h3, 1'b1);
    rd(2'd0, 4'h3, 1'b0);
    rd(2'd1, 4'h3, 1'b1);
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'h3; par_inj = 1'b1;
    rd(2'd2, 4'h3, 1'b1);
    wr_en = 1'b0; par_inj = 1'b0;
    rd(2'd2, 4'h3, 1'b1);
`endif

    step();
    step();
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
